// File: rtl/cmos_pkg.sv
// Shared types, constants and SCCB line-level helpers for the camera init master.
package cmos_pkg;

    typedef enum logic [3:0] {
        PWR_OFF,
        PWR_RST,
        PWR_WAIT,
        FETCH,
        DELAY,
        START,
        BITS,
        STOP,
        GAP,
        DONE
    } state_e;

    localparam logic [15:0]  SCCB_TERM      = 16'hFFFF;
    localparam logic [7:0]   SCCB_DELAY_REG = 8'hF0;
    localparam int unsigned  SCCB_BITS      = 27;
    localparam int unsigned  SCCB_QUARTERS  = 120;
    localparam int unsigned  SLOT_W         = 5;

    // One sample of the three SCCB pad controls.
    typedef struct packed {
        logic c;
        logic d;
        logic oe;
    } sccb_bus_t;

    localparam sccb_bus_t BUS_IDLE = '{c: 1'b1, d: 1'b1, oe: 1'b1};

    // Ninth slot of each byte is the don't-care/ACK slot where the pad is released.
    function automatic logic is_ack_slot(input logic [SLOT_W-1:0] slot);
        return (slot == SLOT_W'(8)) || (slot == SLOT_W'(17)) || (slot == SLOT_W'(26));
    endfunction

    // 27 slots MSB first: address, X, register, X, value, X (X slots carry 1).
    function automatic logic [SCCB_BITS-1:0] sccb_frame(input logic [7:0] dev, input logic [15:0] entry);
        return {dev, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
    endfunction

    // Pad levels for a given phase, quarter and bit slot.
    function automatic sccb_bus_t sccb_levels(
        input state_e                st,
        input logic [1:0]            q,
        input logic [SLOT_W-1:0]     slot,
        input logic [SCCB_BITS-1:0]  frame
    );
        sccb_bus_t              b;
        logic [SCCB_BITS-1:0]   sh;
        b  = BUS_IDLE;
        sh = frame << slot;
        case (st)
            START: b.d = ~q[1];
            BITS: begin
                b.c  = q[1];
                b.d  = sh[SCCB_BITS-1];
                b.oe = ~is_ack_slot(slot);
            end
            STOP: begin
                b.c = (q != 2'd0);
                b.d = q[1];
            end
            default: b = BUS_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cmos_sccb_init_if.sv
// Camera-side pins: power control plus the SCCB clock/data pad controls.
interface cmos_sccb_if;
    logic cmos_pwdn;
    logic cmos_reset_n;
    logic sio_c;
    logic sio_d_out;
    logic sio_d_oe;

    modport master (
        output cmos_pwdn,
        output cmos_reset_n,
        output sio_c,
        output sio_d_out,
        output sio_d_oe
    );

    modport slave (
        input cmos_pwdn,
        input cmos_reset_n,
        input sio_c,
        input sio_d_out,
        input sio_d_oe
    );
endinterface

// File: rtl/cmos_sccb_init_rom.sv
// Default sensor register table; {reg, value} per index, F0 = millisecond delay, FFFF = end.
module cmos_reg_rom
    import cmos_pkg::*;
#(
    parameter int unsigned ROM_AW = 8
) (
    input  logic [ROM_AW-1:0] index,
    output logic [15:0]       data
);

    // Combinational table lookup.
    always_comb begin
        data = SCCB_TERM;
        case (index)
            ROM_AW'(0): data = 16'h1280;
            ROM_AW'(1): data = 16'hF00A;
            ROM_AW'(2): data = 16'h1101;
            ROM_AW'(3): data = 16'h1214;
            ROM_AW'(4): data = 16'h8C00;
            default:    data = SCCB_TERM;
        endcase
    end

endmodule

// File: rtl/cmos_sccb_init.sv
// Camera power-up sequencer and SCCB write master walking an external register table.
module cmos_sccb_init
    import cmos_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 125,
    parameter int unsigned MS_CYCLES = 50000,
    parameter logic [7:0]  DEV_ADDR  = 8'h42,
    parameter int unsigned ROM_AW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    cmos_sccb_if.master        cam,
    output logic               busy,
    output logic               done,
    output logic [ROM_AW-1:0]  rom_index,
    input  logic [15:0]        rom_data
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W  = 32;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [1:0]             quarter_q, quarter_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [SCCB_BITS-1:0]   frame_q, frame_d;
    logic [ROM_AW-1:0]      rom_index_q, rom_index_d;
    sccb_bus_t              bus_q, bus_d;
    logic                   pwdn_q, pwdn_d;
    logic                   rst_n_q, rst_n_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   bus_state;
    logic                   q_tick;
    logic                   last_q;
    logic                   entry_end;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PWR_OFF;
            cnt_q       <= '0;
            tick_q      <= '0;
            quarter_q   <= '0;
            slot_q      <= '0;
            frame_q     <= '0;
            rom_index_q <= '0;
            bus_q       <= BUS_IDLE;
            pwdn_q      <= 1'b1;
            rst_n_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            quarter_q   <= quarter_d;
            slot_q      <= slot_d;
            frame_q     <= frame_d;
            rom_index_q <= rom_index_d;
            bus_q       <= bus_d;
            pwdn_q      <= pwdn_d;
            rst_n_q     <= rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state, timebase and output levels; outputs decode the next state so they align with it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tick_d      = '0;
        quarter_d   = quarter_q;
        slot_d      = slot_q;
        frame_d     = frame_q;
        rom_index_d = rom_index_q;
        entry_end   = 1'b0;

        bus_state = (state_q == START) || (state_q == BITS) ||
                    (state_q == STOP)  || (state_q == GAP);
        q_tick    = bus_state && (tick_q == TICK_W'(TICK_DIV - 1));
        last_q    = q_tick && (quarter_q == 2'd3);

        if (bus_state && !q_tick) begin
            tick_d = tick_q + TICK_W'(1);
        end
        if (q_tick) begin
            quarter_d = quarter_q + 2'd1;
        end

        case (state_q)
            PWR_OFF: begin
                if (cnt_q == CNT_W'(MS_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = PWR_RST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PWR_RST: begin
                if (cnt_q == CNT_W'(MS_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = PWR_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PWR_WAIT: begin
                if (cnt_q == CNT_W'(MS_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FETCH: begin
                if (rom_data == SCCB_TERM) begin
                    state_d = DONE;
                end else if (rom_data[15:8] == SCCB_DELAY_REG) begin
                    // A zero delay skips the DELAY state entirely.
                    if (rom_data[7:0] == 8'd0) begin
                        entry_end = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(rom_data[7:0]) * CNT_W'(MS_CYCLES);
                        state_d = DELAY;
                    end
                end else begin
                    frame_d = sccb_frame(DEV_ADDR, rom_data);
                    slot_d  = '0;
                    state_d = START;
                end
            end
            DELAY: begin
                // Exactly val*MS_CYCLES cycles are spent here.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d     = '0;
                    entry_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            START: begin
                if (last_q) begin
                    state_d = BITS;
                end
            end
            BITS: begin
                if (last_q) begin
                    if (slot_q == SLOT_W'(SCCB_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
            STOP: begin
                if (last_q) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (last_q) begin
                    entry_end = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    rom_index_d = '0;
                    state_d     = FETCH;
                end
            end
            default: state_d = PWR_OFF;
        endcase

        // The last table index acts as a terminator rather than wrapping to 0.
        if (entry_end) begin
            if (rom_index_q == {ROM_AW{1'b1}}) begin
                state_d = DONE;
            end else begin
                rom_index_d = rom_index_q + ROM_AW'(1);
                state_d     = FETCH;
            end
        end

        pwdn_d  = (state_d == PWR_OFF);
        rst_n_d = (state_d != PWR_OFF) && (state_d != PWR_RST);
        busy_d  = (state_d != DONE);
        done_d  = (state_d == DONE);
        bus_d   = sccb_levels(state_d, quarter_d, slot_d, frame_d);
    end

    assign cam.cmos_pwdn    = pwdn_q;
    assign cam.cmos_reset_n = rst_n_q;
    assign cam.sio_c        = bus_q.c;
    assign cam.sio_d_out    = bus_q.d;
    assign cam.sio_d_oe     = bus_q.oe;
    assign busy             = busy_q;
    assign done             = done_q;
    assign rom_index        = rom_index_q;

endmodule

// File: tb/tb_cmos_sccb_init.sv
// Directed bench for cmos_sccb_init with a bench-owned register table and an SCCB line decoder.
module tb_cmos_sccb_init;

    localparam int TD = 2;
    localparam int MS = 10;

    logic        clk;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  rom_index;
    logic [15:0] rom_data;
    logic [15:0] tbl [256];
    logic [7:0]  probe_idx = 8'd0;
    logic [15:0] probe_data;

    int checks   = 0;
    int failures = 0;

    int cyc      = 0;
    int mon_err  = 0;
    int oe_runs  = 0;
    bit pwr_seen = 1'b0;
    logic [23:0] frames[$];
    int          fstart[$];
    int          fstop[$];

    cmos_sccb_if cam ();

    cmos_sccb_init #(
        .TICK_DIV (TD),
        .MS_CYCLES(MS),
        .DEV_ADDR (8'h42),
        .ROM_AW   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cam      (cam),
        .busy     (busy),
        .done     (done),
        .rom_index(rom_index),
        .rom_data (rom_data)
    );

    cmos_reg_rom #(.ROM_AW(8)) rom (
        .index(probe_idx),
        .data (probe_data)
    );

    assign rom_data = tbl[rom_index];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // SCCB decoder: start/stop conditions, bits on SCL rise, ACK-slot release and bit period.
    initial begin
        logic        pc, pd, c, d, in_frame;
        int          nbits, last_rise, oe_run;
        logic [26:0] bits;
        pc = 1'b1; pd = 1'b1; in_frame = 1'b0;
        nbits = 0; last_rise = 0; oe_run = 0; bits = '0;
        forever begin
            @(negedge clk);
            c = cam.sio_c;
            d = cam.sio_d_oe ? cam.sio_d_out : 1'b1;
            if (reset) begin
                in_frame = 1'b0;
                nbits    = 0;
                oe_run   = 0;
            end else begin
                if (cam.cmos_pwdn || !cam.cmos_reset_n) pwr_seen = 1'b1;
                if (!cam.sio_d_oe) begin
                    oe_run++;
                end else if (oe_run != 0) begin
                    if (oe_run != 8) mon_err++;
                    oe_runs++;
                    oe_run = 0;
                end
                if (pc && c && pd && !d) begin
                    if (in_frame) mon_err++;
                    in_frame = 1'b1;
                    nbits    = 0;
                    fstart.push_back(cyc);
                end else if (pc && c && !pd && d) begin
                    if (in_frame) begin
                        if (nbits == 27) begin
                            frames.push_back({bits[26:19], bits[17:10], bits[8:1]});
                            fstop.push_back(cyc);
                        end else begin
                            mon_err++;
                        end
                    end
                    in_frame = 1'b0;
                end else if (in_frame && !pc && c && nbits < 27) begin
                    if ((nbits == 8 || nbits == 17 || nbits == 26) == cam.sio_d_oe) mon_err++;
                    if (nbits > 0 && (cyc - last_rise) != 8) mon_err++;
                    last_rise = cyc;
                    bits      = {bits[25:0], d};
                    nbits++;
                end
            end
            pc = c;
            pd = d;
        end
    end

    task automatic clear_log();
        frames.delete();
        fstart.delete();
        fstop.delete();
        pwr_seen = 1'b0;
        oe_runs  = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic load_main_table();
        for (int i = 0; i < 256; i++) tbl[i] = 16'hFFFF;
        tbl[0] = 16'h1280;
        tbl[1] = 16'hF002;
        tbl[2] = 16'h1101;
        tbl[3] = 16'hFFFF;
    endtask

    task automatic test_rom_table();
        logic [7:0]  idx [4];
        logic [15:0] exp [4];
        idx[0] = 8'd0;   exp[0] = 16'h1280;
        idx[1] = 8'd1;   exp[1] = 16'hF00A;
        idx[2] = 8'd2;   exp[2] = 16'h1101;
        idx[3] = 8'd100; exp[3] = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            probe_idx = idx[i];
            #1;
            checks++;
            if (probe_data !== exp[i]) begin
                failures++;
                $display("FAIL rom_entry[%0d]: got %h expected %h", idx[i], probe_data, exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cam.cmos_pwdn !== 1'b1)    begin failures++; $display("FAIL reset_pwdn: got %b expected 1", cam.cmos_pwdn); end
        checks++; if (cam.cmos_reset_n !== 1'b0) begin failures++; $display("FAIL reset_reset_n: got %b expected 0", cam.cmos_reset_n); end
        checks++; if (cam.sio_c !== 1'b1)        begin failures++; $display("FAIL reset_sio_c: got %b expected 1", cam.sio_c); end
        checks++; if (cam.sio_d_out !== 1'b1)    begin failures++; $display("FAIL reset_sio_d: got %b expected 1", cam.sio_d_out); end
        checks++; if (cam.sio_d_oe !== 1'b1)     begin failures++; $display("FAIL reset_sio_oe: got %b expected 1", cam.sio_d_oe); end
        checks++; if (busy !== 1'b0)             begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)             begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (rom_index !== 8'd0)        begin failures++; $display("FAIL reset_rom_index: got %0d expected 0", rom_index); end
    endtask

    // Cycle n = value seen after n rising edges with reset low.
    task automatic test_power();
        int rel;
        int pwdn_fall = -1;
        int rst_rise  = -1;
        int d_fall    = -1;
        clear_log();
        @(posedge clk);
        #1 reset = 1'b0;
        rel = cyc;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (pwdn_fall < 0 && cam.cmos_pwdn === 1'b0) pwdn_fall = cyc - rel;
            if (rst_rise < 0 && cam.cmos_reset_n === 1'b1) rst_rise = cyc - rel;
            if (d_fall < 0 && cam.sio_c === 1'b1 && cam.sio_d_oe === 1'b1 && cam.sio_d_out === 1'b0)
                d_fall = cyc - rel;
        end
        checks++; if (pwdn_fall !== MS)     begin failures++; $display("FAIL power_pwdn_fall: got %0d expected %0d", pwdn_fall, MS); end
        checks++; if (rst_rise !== 2 * MS)  begin failures++; $display("FAIL power_reset_rise: got %0d expected %0d", rst_rise, 2 * MS); end
        // Three power phases, one FETCH cycle, then two START quarters.
        checks++; if (d_fall !== 3 * MS + 1 + 2 * TD) begin failures++; $display("FAIL power_first_start: got %0d expected %0d", d_fall, 3 * MS + 1 + 2 * TD); end
    endtask

    task automatic test_table();
        bit seen;
        wait_done(3000, seen);
        checks++; if (!seen)               begin failures++; $display("FAIL table_done_timeout: got done=%b expected 1", done); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL table_busy: got %b expected 0", busy); end
        checks++; if (rom_index !== 8'd3)  begin failures++; $display("FAIL table_rom_index: got %0d expected 3", rom_index); end
        checks++; if ({cam.sio_c, cam.sio_d_out, cam.sio_d_oe} !== 3'b111) begin failures++; $display("FAIL table_bus_idle: got %b expected 111", {cam.sio_c, cam.sio_d_out, cam.sio_d_oe}); end
        checks++; if (frames.size() !== 2) begin failures++; $display("FAIL table_frame_count: got %0d expected 2", frames.size()); end
        if (frames.size() >= 2 && fstart.size() >= 2) begin
            checks++; if (frames[0] !== 24'h421280) begin failures++; $display("FAIL table_frame0: got %h expected 421280", frames[0]); end
            checks++; if (frames[1] !== 24'h421101) begin failures++; $display("FAIL table_frame1: got %h expected 421101", frames[1]); end
            // Stop -> next start is 17 cycles normally; the delay entry adds its FETCH plus 2 ms.
            checks++; if (fstart[1] - fstop[0] !== 17 + 1 + 2 * MS) begin failures++; $display("FAIL table_delay_gap: got %0d expected %0d", fstart[1] - fstop[0], 17 + 1 + 2 * MS); end
        end
        checks++; if (oe_runs !== 6) begin failures++; $display("FAIL table_ack_release_count: got %0d expected 6", oe_runs); end
        checks++; if (mon_err !== 0) begin failures++; $display("FAIL table_bit_timing: got %0d errors expected 0", mon_err); end
    endtask

    task automatic test_restart_and_busy_start();
        bit seen;
        int s;
        clear_log();
        @(posedge clk);
        #1 start = 1'b1;
        s = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL restart_done_drop: got %b expected 0", done); end
        checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL restart_busy: got %b expected 1", busy); end
        checks++; if (rom_index !== 8'd0) begin failures++; $display("FAIL restart_rom_index: got %0d expected 0", rom_index); end
        // Mid first frame, then inside the delay entry: both must be ignored.
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (148) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(3000, seen);
        checks++; if (!seen)               begin failures++; $display("FAIL restart_done_timeout: got done=%b expected 1", done); end
        checks++; if (frames.size() !== 2) begin failures++; $display("FAIL restart_frame_count: got %0d expected 2", frames.size()); end
        if (frames.size() >= 2 && fstart.size() >= 1) begin
            checks++; if (frames[0] !== 24'h421280) begin failures++; $display("FAIL restart_frame0: got %h expected 421280", frames[0]); end
            checks++; if (frames[1] !== 24'h421101) begin failures++; $display("FAIL restart_frame1: got %h expected 421101", frames[1]); end
            checks++; if (fstart[0] - s !== 1 + 2 * TD) begin failures++; $display("FAIL restart_latency: got %0d expected %0d", fstart[0] - s, 1 + 2 * TD); end
        end
        checks++; if (pwr_seen !== 1'b0)   begin failures++; $display("FAIL restart_no_power_seq: got %b expected 0", pwr_seen); end
        checks++; if (rom_index !== 8'd3)  begin failures++; $display("FAIL restart_rom_index_end: got %0d expected 3", rom_index); end
        checks++; if (mon_err !== 0)       begin failures++; $display("FAIL restart_bit_timing: got %0d errors expected 0", mon_err); end
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        bit second = 1'b0;
        clear_log();
        pulse_start();
        for (int i = 0; i < 1000 && !second; i++) begin
            @(negedge clk);
            if (fstart.size() >= 2) second = 1'b1;
        end
        checks++; if (!second) begin failures++; $display("FAIL midreset_second_frame_timeout: got %0d starts expected 2", fstart.size()); end
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (cam.sio_c !== 1'b1)        begin failures++; $display("FAIL midreset_sio_c: got %b expected 1", cam.sio_c); end
        checks++; if (cam.sio_d_out !== 1'b1)    begin failures++; $display("FAIL midreset_sio_d: got %b expected 1", cam.sio_d_out); end
        checks++; if (cam.sio_d_oe !== 1'b1)     begin failures++; $display("FAIL midreset_sio_oe: got %b expected 1", cam.sio_d_oe); end
        checks++; if (cam.cmos_pwdn !== 1'b1)    begin failures++; $display("FAIL midreset_pwdn: got %b expected 1", cam.cmos_pwdn); end
        checks++; if (cam.cmos_reset_n !== 1'b0) begin failures++; $display("FAIL midreset_reset_n: got %b expected 0", cam.cmos_reset_n); end
        checks++; if (busy !== 1'b0)             begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        repeat (2) @(posedge clk);
        clear_log();
        #1 reset = 1'b0;
        wait_done(3000, seen);
        checks++; if (!seen)               begin failures++; $display("FAIL midreset_done_timeout: got done=%b expected 1", done); end
        checks++; if (pwr_seen !== 1'b1)   begin failures++; $display("FAIL midreset_power_replay: got %b expected 1", pwr_seen); end
        checks++; if (frames.size() !== 2) begin failures++; $display("FAIL midreset_frame_count: got %0d expected 2", frames.size()); end
        if (frames.size() >= 2) begin
            checks++; if (frames[0] !== 24'h421280) begin failures++; $display("FAIL midreset_frame0: got %h expected 421280", frames[0]); end
            checks++; if (frames[1] !== 24'h421101) begin failures++; $display("FAIL midreset_frame1: got %h expected 421101", frames[1]); end
        end
    endtask

    task automatic test_no_terminator();
        bit seen;
        int bad = 0;
        for (int i = 0; i < 256; i++) tbl[i] = 16'h0000;
        clear_log();
        pulse_start();
        wait_done(70000, seen);
        checks++; if (!seen)                 begin failures++; $display("FAIL noterm_done_timeout: got done=%b expected 1", done); end
        checks++; if (rom_index !== 8'd255)  begin failures++; $display("FAIL noterm_rom_index: got %0d expected 255", rom_index); end
        checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL noterm_busy: got %b expected 0", busy); end
        checks++; if (frames.size() !== 256) begin failures++; $display("FAIL noterm_frame_count: got %0d expected 256", frames.size()); end
        foreach (frames[i]) if (frames[i] !== 24'h420000) bad++;
        checks++; if (bad !== 0)             begin failures++; $display("FAIL noterm_frame_values: got %0d bad frames expected 0", bad); end
        checks++; if (mon_err !== 0)         begin failures++; $display("FAIL noterm_bit_timing: got %0d errors expected 0", mon_err); end
    endtask

    initial begin
        load_main_table();
        test_rom_table();
        test_reset();
        test_power();
        test_table();
        test_restart_and_busy_start();
        test_reset_mid_frame();
        test_no_terminator();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
